seg7_scan_ctrl: RTL and testbench

Time-multiplexing scan controller that shares one `Decoder8` instance between `NDIG` seven-segment digits. It holds a double-buffered display word and cycles a digit index. For each digit it presents the 4-bit code to the decoder's `IN` and drives the active-low common-anode selects, with a blanking gap between digits to prevent ghosting. New display values arrive over a valid/ready load handshake and are committed only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/seg7_scan_ctrl_if.sv | 22 ++
 rtl/seg7_scan_ctrl.sv | 128 ++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/seg7_scan_ctrl_if.sv
// Load handshake and display drive signals of the seven-segment scan controller.
interface seg7_scan_ctrl_if #(
  parameter int NDIG = 4
);
  logic                  enable;
  logic                  ld_valid;
  logic [4*NDIG-1:0]     ld_data;
  logic                  ld_ready;
  logic [3:0]            dec_in;
  logic [NDIG-1:0]       an;
  logic                  frame_tick;

  modport master (
    output enable, ld_valid, ld_data,
    input  ld_ready, dec_in, an, frame_tick
  );

  modport slave (
    input  enable, ld_valid, ld_data,
    output ld_ready, dec_in, an, frame_tick
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for NDIG common-anode digits sharing one
// decoder. Double-buffered display word, committed only at frame boundaries
// (or while scanning is disabled).
module seg7_scan_ctrl #(
  parameter int NDIG  = 4,
  parameter int DIV   = 50000,
  parameter int BLANK = 5000,
  parameter int LZB   = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  seg7_scan_ctrl_if.slave bus
);
  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(NDIG);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*NDIG-1:0]   disp_q, disp_d;
  logic [4*NDIG-1:0]   pend_q, pend_d;
  logic                pend_full_q, pend_full_d;
  logic [NDIG-1:0]     an_q, an_d;
  logic [3:0]          dec_in_q, dec_in_d;
  logic                ld_ready_q;
  logic                frame_tick_q, frame_tick_d;
  logic [NDIG-1:0]     supp;
  logic                nz;
  logic                commit;
  logic                accept;

  // Outputs are computed from next-state values so the registered AN/DEC_IN
  // line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    disp_d      = disp_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    an_d        = '1;
    dec_in_d    = dec_in_q;
    supp        = '0;
    nz          = 1'b0;

    commit = pend_full_q && (frame_tick_q || !bus.enable);
    accept = bus.ld_valid && ld_ready_q;

    if (!bus.enable) begin
      state_d = ST_BLANK;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_BLANK: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(BLANK - 1)) state_d = ST_SHOW;
        end
        default: begin
          if (cnt_q == CW'(DIV - 1)) begin
            cnt_d   = '0;
            idx_d   = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + IW'(1);
            state_d = ST_BLANK;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      endcase
    end

    // Commit before accept: a word accepted this cycle stays pending.
    if (commit) begin
      disp_d      = pend_q;
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pend_d      = bus.ld_data;
      pend_full_d = 1'b1;
    end

    // Scan from the most significant digit down; a digit is suppressed while
    // it and everything above it is zero. Digit 0 always shows.
    for (int unsigned i = 0; i < NDIG; i++) begin
      nz = nz | (disp_d[4*(NDIG-1-i) +: 4] != 4'd0);
      if ((LZB != 0) && ((NDIG - 1 - i) != 0) && !nz) supp[NDIG-1-i] = 1'b1;
    end

    if (state_d == ST_SHOW && !supp[idx_d]) an_d[idx_d] = 1'b0;
    if (state_d == ST_BLANK) dec_in_d = disp_d[{idx_d, 2'b00} +: 4];

    frame_tick_d = bus.enable && (state_d == ST_SHOW) &&
                   (idx_d == IW'(NDIG - 1)) && (cnt_d == CW'(DIV - 1));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
      an_q         <= '1;
      dec_in_q     <= '0;
      ld_ready_q   <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      an_q         <= an_d;
      dec_in_q     <= dec_in_d;
      ld_ready_q   <= !pend_full_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.dec_in     = dec_in_q;
  assign bus.ld_ready   = ld_ready_q;
  assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with NDIG=4, DIV=8, BLANK=2, LZB=1.
module tb_seg7_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl_if #(.NDIG(4)) bus ();

  seg7_scan_ctrl #(.NDIG(4), .DIV(8), .BLANK(2), .LZB(1)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input string tag);
    int n = 0;
    while (bus.frame_tick !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    chk(tag, bus.frame_tick, 1'b1);
  endtask

  // Called in a FRAME_TICK cycle; checks the 32 clocks of the next frame.
  task automatic check_frame(input string tag, input logic [15:0] dval,
                             input logic [3:0] supp, input logic rdy);
    logic [3:0] ea;
    logic [3:0] ed;
    int slot, pos;
    for (int c = 0; c < 32; c++) begin
      tick();
      if (c == 0) bus.ld_valid = 1'b0;
      slot = c / 8;
      pos  = c % 8;
      ea = 4'hF;
      if (pos >= 2 && !supp[slot]) ea[slot] = 1'b0;
      ed = dval[4*slot +: 4];
      chk({tag, "_an"},   bus.an, ea);
      chk({tag, "_dec"},  bus.dec_in, ed);
      chk({tag, "_tick"}, bus.frame_tick, (c == 31));
      chk({tag, "_rdy"},  bus.ld_ready, rdy);
    end
  endtask

  task automatic load(input logic [15:0] d);
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    tick();
    bus.ld_valid = 1'b0;
  endtask

  initial begin
    bus.enable   = 1'b1;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;

    // Reset
    repeat (3) tick();
    chk("rst_an",   bus.an, 4'hF);
    chk("rst_dec",  bus.dec_in, 4'h0);
    chk("rst_rdy",  bus.ld_ready, 1'b1);
    chk("rst_tick", bus.frame_tick, 1'b0);
    rst = 1'b0;
    tick();
    chk("rel1_an", bus.an, 4'hF);
    tick();
    chk("rel2_an",  bus.an, 4'hE);
    chk("rel2_dec", bus.dec_in, 4'h0);

    // Scan order
    load(16'h1234);
    wait_tick("scan_wait");
    check_frame("scan", 16'h1234, 4'b0000, 1'b1);

    // Handshake / backpressure
    repeat (10) tick();
    chk("hs_rdy0", bus.ld_ready, 1'b1);
    load(16'h5678);
    chk("hs_busy", bus.ld_ready, 1'b0);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 16'h9999;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hs_ign_rdy", bus.ld_ready, 1'b0);
    end
    bus.ld_valid = 1'b0;
    wait_tick("hs_wait");
    chk("hs_rdy_tick", bus.ld_ready, 1'b0);
    check_frame("hs", 16'h5678, 4'b0000, 1'b1);

    // Tick collision: accepted on the FRAME_TICK edge, shown one frame later
    bus.ld_valid = 1'b1;
    bus.ld_data  = 16'h0042;
    check_frame("col_old", 16'h5678, 4'b0000, 1'b0);
    check_frame("col_new", 16'h0042, 4'b1100, 1'b1);

    // All-zero value shows a single 0
    repeat (3) tick();
    load(16'h0000);
    wait_tick("zero_wait");
    check_frame("zero", 16'h0000, 4'b1110, 1'b1);

    // Enable drop during SHOW of digit 2
    repeat (3) tick();
    load(16'h1234);
    wait_tick("en_wait");
    repeat (20) tick();
    chk("en_show2", bus.an, 4'hB);
    bus.enable = 1'b0;
    tick();
    chk("en_off_an",   bus.an, 4'hF);
    chk("en_off_tick", bus.frame_tick, 1'b0);
    chk("en_off_dec",  bus.dec_in, 4'h4);
    load(16'h5678);
    chk("en_off_busy", bus.ld_ready, 1'b0);
    tick();
    chk("en_off_commit_dec", bus.dec_in, 4'h8);
    chk("en_off_commit_rdy", bus.ld_ready, 1'b1);
    chk("en_off_an2", bus.an, 4'hF);
    bus.enable = 1'b1;
    tick();
    chk("en_re_blank", bus.an, 4'hF);
    tick();
    chk("en_re_show",  bus.an, 4'hE);
    chk("en_re_dec",   bus.dec_in, 4'h8);

    // Reset with a pending load
    tick();
    load(16'h9999);
    chk("rp_busy", bus.ld_ready, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rp_an",  bus.an, 4'hF);
    chk("rp_rdy", bus.ld_ready, 1'b1);
    chk("rp_dec", bus.dec_in, 4'h0);
    wait_tick("rp_wait");
    check_frame("rp", 16'h0000, 4'b1110, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
